// File: rtl/uart_engine.sv
// Full-duplex UART engine: per-frame parity/stop configuration, valid/ready on both sides,
// per-entry parity/framing flags and overrun pulse. Define UART_RX_FIFO_EN for an RX FIFO.
module uart_engine #(
    parameter int CLK_BITS      = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CLK_BITS-1:0]   clk_per_bit,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun
);
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CLK_BITS-1:0] CPB_MIN = CLK_BITS'(4);
    localparam logic [CLK_BITS-1:0] ONE     = CLK_BITS'(1);
    localparam logic [IDX_W-1:0]    LAST_DB = IDX_W'(DATA_WIDTH - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  parity_err;
        logic                  frame_err;
    } rx_entry_t;

    logic [CLK_BITS-1:0] cpb_eff;
    assign cpb_eff = (clk_per_bit < CPB_MIN) ? CPB_MIN : clk_per_bit;

    // ------------------------------------------------------------------ TX
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    tx_state_t             tx_state, tx_state_n;
    logic [CLK_BITS-1:0]   tx_cpb, tx_cnt;
    logic [IDX_W-1:0]      tx_idx;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par_en, tx_par_bit, tx_stop2;
    logic                  tx_bit_end;
    logic                  tx_accept;

    assign tx_accept = tx_valid && tx_ready;
    assign tx_ready  = (tx_state == TX_IDLE);
    assign tx_busy   = !tx_ready;

    always_comb begin
        tx_state_n = tx_state;
        tx_bit_end = (tx_cnt == tx_cpb - ONE);
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_state_n = TX_START;
            TX_START:  if (tx_bit_end) tx_state_n = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_idx == LAST_DB)
                           tx_state_n = tx_par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
            TX_STOP:   if (tx_bit_end && (!tx_stop2 || tx_idx[0])) tx_state_n = TX_IDLE;
            default:   tx_state_n = TX_IDLE;
        endcase
    end

    // Decoded from state so reset forces the line high without waiting for a clock
    always_comb begin
        case (tx_state)
            TX_START:  tx_out = 1'b0;
            TX_DATA:   tx_out = tx_shift[0];
            TX_PARITY: tx_out = tx_par_bit;
            default:   tx_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_cpb     <= CPB_MIN;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_stop2   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_accept) begin
                tx_cpb     <= cpb_eff;
                tx_shift   <= tx_data;
                tx_par_en  <= ^parity_mode;
                tx_par_bit <= parity_mode[1] ? ~^tx_data : ^tx_data;
                tx_stop2   <= stop2;
                tx_cnt     <= '0;
                tx_idx     <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    tx_idx <= (tx_state_n != tx_state) ? '0 : tx_idx + IDX_W'(1);
                    if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
                end else begin
                    tx_cnt <= tx_cnt + ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    rx_state_t             rx_state, rx_state_n;
    logic                  rx_meta, rx_s;
    logic [CLK_BITS-1:0]   rx_cpb, rx_cnt, rx_half;
    logic [IDX_W-1:0]      rx_idx;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_par_en, rx_par_odd, rx_stop2;
    logic                  rx_perr, rx_ferr;
    logic                  rx_tick, rx_par_exp, rx_write;
    rx_entry_t             wr_entry;

    // Synchroniser resets high so the line looks idle coming out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_write   = 1'b0;
        rx_half    = (rx_cpb - ONE) >> 1;
        rx_tick    = (rx_state == RX_START) ? (rx_cnt == rx_half - ONE)
                                            : (rx_cnt == rx_cpb - ONE);
        rx_par_exp = rx_par_odd ? ~^rx_shift : ^rx_shift;
        case (rx_state)
            RX_IDLE:   if (!rx_s) rx_state_n = RX_START;
            RX_START:  if (rx_tick) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_idx == LAST_DB)
                           rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_state_n = RX_STOP;
            RX_STOP:   if (rx_tick && (!rx_stop2 || rx_idx[0])) begin
                           rx_state_n = RX_IDLE;
                           rx_write   = 1'b1;
                       end
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    assign wr_entry = '{data: rx_shift, parity_err: rx_perr, frame_err: rx_ferr | ~rx_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cpb     <= CPB_MIN;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_stop2   <= 1'b0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            if (rx_state == RX_IDLE) begin
                if (!rx_s) begin
                    rx_cpb     <= cpb_eff;
                    rx_par_en  <= ^parity_mode;
                    rx_par_odd <= parity_mode[1];
                    rx_stop2   <= stop2;
                    rx_cnt     <= '0;
                    rx_idx     <= '0;
                    rx_perr    <= 1'b0;
                    rx_ferr    <= 1'b0;
                end
            end else if (rx_tick) begin
                rx_cnt <= '0;
                rx_idx <= (rx_state_n != rx_state) ? '0 : rx_idx + IDX_W'(1);
                case (rx_state)
                    RX_DATA:   rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
                    RX_PARITY: rx_perr  <= (rx_s != rx_par_exp);
                    RX_STOP:   rx_ferr  <= rx_ferr | ~rx_s;
                    default:   ;
                endcase
            end else begin
                rx_cnt <= rx_cnt + ONE;
            end
        end
    end

    // ------------------------------------------------------------ RX buffer
    rx_entry_t rx_head;
    logic      rx_consume;
    logic      rx_ovr_q;

    assign rx_consume    = rx_valid && rx_ready;
    assign rx_data       = rx_head.data;
    assign rx_parity_err = rx_head.parity_err;
    assign rx_frame_err  = rx_head.frame_err;
    assign rx_overrun    = rx_ovr_q;

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    rx_entry_t        mem [RX_FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             fifo_full, fifo_empty;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rx_valid   = !fifo_empty;
    assign rx_head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_ovr_q <= 1'b0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            // A pop in the same cycle frees the slot, so a full FIFO can still accept
            rx_ovr_q <= rx_write && fifo_full && !rx_consume;
            if (rx_write && (!fifo_full || rx_consume)) begin
                mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rx_consume) rd_ptr <= rd_ptr + 1'b1;
        end
    end
`else
    logic hold_vld;
    assign rx_valid = hold_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_head  <= '0;
            hold_vld <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else begin
            rx_ovr_q <= rx_write && hold_vld && !rx_ready;
            if (rx_write && (!hold_vld || rx_ready)) begin
                rx_head  <= wr_entry;
                hold_vld <= 1'b1;
            end else if (rx_consume) begin
                hold_vld <= 1'b0;
            end
        end
    end
`endif

endmodule
